fan_speed_sequencer: RTL and testbench
======================================

FAN_SPEED_SEQUENCER -- requirements
Module: fan_speed_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, default 4: number of PWM duty inputs (legal 2..16).
REQ-002 Parameter SWEEP_SEC, default 2: seconds per sweep step (legal 1..15).
REQ-003 Parameter TIMER_STEP_SEC, default 20: seconds added per timer press.
REQ-004 Parameter TIMER_MAX_SEC, default 60: timer ceiling (legal ≤127).
REQ-005 i_clk  in  1  single system clock, all state on rising edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_pwm  in  NUM_LEVELS  PWM streams, index 0 = lowest duty.
REQ-008 i_btn_mode  in  1  one-cycle debounced pulse, cycles the mode.
REQ-009 i_btn_speed  in  1  one-cycle pulse, next speed level.
REQ-010 i_btn_timer  in  1  one-cycle pulse, adds to the auto-off timer.
REQ-011 i_tick_1hz  in  1  one-cycle pulse once per second.
REQ-012 o_pwm  out  1  selected fan drive, registered.
REQ-013 o_level  out  clog2(NUM_LEVELS)  current level index.
REQ-014 o_mode  out  2  00 OFF, 01 MANUAL, 10 SWEEP.
REQ-015 o_sec_left  out  7  remaining auto-off seconds, 0 = timer inactive.

Function
REQ-016 FSM states OFF, MANUAL, SWEEP; i_btn_mode transitions OFF->MANUAL->SWEEP->OFF.
REQ-017 Entering MANUAL sets o_level=0; entering SWEEP keeps o_level, sets direction up, clears sweep second counter.
REQ-018 MANUAL: i_btn_speed increments o_level, NUM_LEVELS-1 wraps to 0; ignored in OFF and SWEEP.
REQ-019 SWEEP: sweep counter counts i_tick_1hz; on SWEEP_SEC-th tick level steps one in current direction and counter clears.
REQ-020 SWEEP direction reverses at ends: sequence for NUM_LEVELS=4 is 0,1,2,3,2,1,0,1,...; no level repeated at the turn.
REQ-021 o_pwm = i_pwm[o_level] registered one cycle, in MANUAL/SWEEP; forced 0 in OFF (also one-cycle registered).
REQ-022 Timer: i_btn_timer in MANUAL/SWEEP adds TIMER_STEP_SEC, saturating at TIMER_MAX_SEC; press while already at TIMER_MAX_SEC clears to 0; ignored in OFF.
REQ-023 Each i_tick_1hz with o_sec_left>0 decrements it; decrement from 1 to 0 forces OFF the same edge.
REQ-024 Entering OFF by any path clears o_level, o_sec_left, sweep counter, direction.
REQ-025 Priority same cycle: timer expiry > i_btn_mode > i_btn_speed; expiry suppresses all button effects.
REQ-026 Tick and i_btn_timer same cycle (no expiry): result = min(old-1+TIMER_STEP_SEC, TIMER_MAX_SEC).
REQ-027 Mode change and sweep step same cycle: mode change wins, no step.
REQ-028 All arithmetic unsigned; no width overflow for any legal parameters.

Reset
REQ-029 i_reset_n low asynchronously forces OFF, o_level=0, o_sec_left=0, o_pwm=0, direction up, counters 0.
REQ-030 Reset asserted mid-sweep or mid-countdown abandons it; first release edge starts from OFF, no pending press retained.

Configuration
REQ-031 Macro FAN_TIMER_EN defined: auto-off timer per REQ-022..026 compiled in.
REQ-032 FAN_TIMER_EN undefined: timer logic absent, i_btn_timer ignored, o_sec_left tied 0, no auto-off; all other behaviour unchanged.

Verification
REQ-033 Reset, i_pwm=4'b1111 -> o_mode=00, o_level=0, o_pwm=0, o_sec_left=0.
REQ-034 mode press, 5 speed presses, i_pwm[1]=1 others 0 -> o_level 1,2,3,0,1; o_pwm=1 one cycle after level 1.
REQ-035 SWEEP from level 0, SWEEP_SEC=2, 14 ticks -> o_level 1,2,3,2,1,0,1 every second tick.
REQ-036 MANUAL, 4 timer presses -> o_sec_left 20,40,60,0; then 1 press, 20 ticks -> OFF on 20th tick, o_pwm=0 next cycle.
REQ-037 o_sec_left=1, tick and i_btn_mode same cycle -> OFF, o_sec_left=0; tick + timer press at 40 -> 59.
REQ-038 Build without FAN_TIMER_EN, 3 timer presses, 100 ticks in MANUAL -> o_sec_left=0, mode stays MANUAL.

Source files
------------

// File: rtl/fan_speed_sequencer.sv
// Fan drive sequencer: OFF/MANUAL/SWEEP modes selecting one of several PWM streams.
// Optional auto-off countdown timer is compiled in when FAN_TIMER_EN is defined.
module fan_speed_sequencer #(
  parameter int unsigned NUM_LEVELS     = 4,
  parameter int unsigned SWEEP_SEC      = 2,
  parameter int unsigned TIMER_STEP_SEC = 20,
  parameter int unsigned TIMER_MAX_SEC  = 60
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_LEVELS-1:0]         i_pwm,
  input  logic                          i_btn_mode,
  input  logic                          i_btn_speed,
  input  logic                          i_btn_timer,
  input  logic                          i_tick_1hz,
  output logic                          o_pwm,
  output logic [$clog2(NUM_LEVELS)-1:0] o_level,
  output logic [1:0]                    o_mode,
  output logic [6:0]                    o_sec_left
);

  localparam int unsigned LW = $clog2(NUM_LEVELS);
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 7;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_MANUAL = 2'b01,
    ST_SWEEP  = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          dir_up_q, dir_up_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          pwm_q, pwm_d;

  logic [SW-1:0] sec_next_c;
  logic          expire_c;

`ifdef FAN_TIMER_EN
  logic          dec_c;
  logic [SW-1:0] base_c;

  // Countdown plus press handling; a tick in the same cycle is applied before the add.
  always_comb begin
    dec_c      = i_tick_1hz && (sec_q != '0);
    base_c     = dec_c ? sec_q - SW'(1) : sec_q;
    sec_next_c = base_c;
    if (i_btn_timer && (state_q != ST_OFF)) begin
      if (!dec_c && (sec_q == SW'(TIMER_MAX_SEC))) begin
        sec_next_c = '0;
      end else if ((32'(base_c) + TIMER_STEP_SEC) >= TIMER_MAX_SEC) begin
        sec_next_c = SW'(TIMER_MAX_SEC);
      end else begin
        sec_next_c = base_c + SW'(TIMER_STEP_SEC);
      end
    end
    expire_c = i_tick_1hz && (sec_q == SW'(1));
  end
`else
  logic unused_btn_timer;
  assign unused_btn_timer = i_btn_timer;
  assign sec_next_c       = '0;
  assign expire_c         = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_OFF;
      level_q  <= '0;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      sec_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
      sec_q    <= sec_d;
      pwm_q    <= pwm_d;
    end
  end

  // Next-state: expiry beats mode press, mode press beats speed press and sweep step.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    sec_d    = sec_q;
    pwm_d    = 1'b0;
    if (state_q != ST_OFF) begin
      pwm_d = i_pwm[level_q];
    end

    if (expire_c) begin
      state_d  = ST_OFF;
      level_d  = '0;
      dir_up_d = 1'b1;
      cnt_d    = '0;
      sec_d    = '0;
    end else begin
      sec_d = sec_next_c;
      if (i_btn_mode) begin
        unique case (state_q)
          ST_OFF: begin
            state_d = ST_MANUAL;
            level_d = '0;
          end
          ST_MANUAL: begin
            state_d  = ST_SWEEP;
            dir_up_d = 1'b1;
            cnt_d    = '0;
          end
          default: begin
            state_d  = ST_OFF;
            level_d  = '0;
            dir_up_d = 1'b1;
            cnt_d    = '0;
            sec_d    = '0;
          end
        endcase
      end else if ((state_q == ST_MANUAL) && i_btn_speed) begin
        level_d = (level_q == LW'(NUM_LEVELS - 1)) ? '0 : level_q + LW'(1);
      end else if ((state_q == ST_SWEEP) && i_tick_1hz) begin
        if ((cnt_q + CW'(1)) == CW'(SWEEP_SEC)) begin
          cnt_d = '0;
          if (dir_up_q) begin
            if (level_q == LW'(NUM_LEVELS - 1)) begin
              level_d  = level_q - LW'(1);
              dir_up_d = 1'b0;
            end else begin
              level_d = level_q + LW'(1);
            end
          end else begin
            if (level_q == '0) begin
              level_d  = level_q + LW'(1);
              dir_up_d = 1'b1;
            end else begin
              level_d = level_q - LW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign o_pwm      = pwm_q;
  assign o_level    = level_q;
  assign o_mode     = state_q;
  assign o_sec_left = sec_q;

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Self-checking bench for fan_speed_sequencer: directed steps then random traffic vs. a reference model.
module tb_fan_speed_sequencer;

  localparam int N     = 4;
  localparam int SWS   = 2;
  localparam int STEP  = 20;
  localparam int TMAX  = 60;
`ifdef FAN_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pwm_in;
  logic         btn_mode, btn_speed, btn_timer, tick;
  logic         o_pwm;
  logic [1:0]   o_level;
  logic [1:0]   o_mode;
  logic [6:0]   o_sec_left;

  int total = 0;
  int bad   = 0;

  // Reference model: sweep position is a phase on a triangle wave of period 2N-2.
  int m_mode, m_level, m_phase, m_cnt, m_sec;
  logic m_pwm;

  always #5 clk = ~clk;

  fan_speed_sequencer dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_pwm       (pwm_in),
    .i_btn_mode  (btn_mode),
    .i_btn_speed (btn_speed),
    .i_btn_timer (btn_timer),
    .i_tick_1hz  (tick),
    .o_pwm       (o_pwm),
    .o_level     (o_level),
    .o_mode      (o_mode),
    .o_sec_left  (o_sec_left)
  );

  function automatic int tri_level(input int ph);
    return (ph < N) ? ph : (2 * N - 2 - ph);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_phase = 0; m_cnt = 0; m_sec = 0; m_pwm = 1'b0;
  endtask

  task automatic model_off();
    m_mode = 0; m_level = 0; m_cnt = 0; m_sec = 0;
  endtask

  task automatic model_step(input bit bm, input bit bs, input bit bt, input bit tk,
                            input logic [N-1:0] pw);
    int ns;
    bit dec;
    m_pwm = (m_mode != 0) ? pw[m_level] : 1'b0;
    if (TEN && tk && m_sec == 1) begin
      model_off();
    end else begin
      ns  = m_sec;
      dec = TEN && tk && (m_sec > 0);
      if (dec) ns = m_sec - 1;
      if (TEN && bt && m_mode != 0) begin
        if (!dec && m_sec == TMAX) ns = 0;
        else ns = (ns + STEP > TMAX) ? TMAX : ns + STEP;
      end
      m_sec = ns;
      if (bm) begin
        if (m_mode == 0) begin
          m_mode = 1; m_level = 0;
        end else if (m_mode == 1) begin
          m_mode = 2; m_phase = m_level; m_cnt = 0;
        end else begin
          model_off();
        end
      end else if (m_mode == 1 && bs) begin
        m_level = (m_level + 1) % N;
      end else if (m_mode == 2 && tk) begin
        m_cnt++;
        if (m_cnt == SWS) begin
          m_cnt   = 0;
          m_phase = (m_phase + 1) % (2 * N - 2);
          m_level = tri_level(m_phase);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".mode"},  32'(o_mode),     32'(m_mode));
    chk({tag, ".level"}, 32'(o_level),    32'(m_level));
    chk({tag, ".sec"},   32'(o_sec_left), 32'(m_sec));
    chk({tag, ".pwm"},   32'(o_pwm),      32'(m_pwm));
  endtask

  task automatic cyc(input string tag, input bit bm, input bit bs, input bit bt, input bit tk,
                     input logic [N-1:0] pw);
    btn_mode = bm; btn_speed = bs; btn_timer = bt; tick = tk; pwm_in = pw;
    @(posedge clk); #1;
    model_step(bm, bs, bt, tk, pw);
    btn_mode = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0; tick = 1'b0;
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  int lv_exp [7] = '{1, 2, 3, 2, 1, 0, 1};
  int sp_exp [5] = '{1, 2, 3, 0, 1};
  int tm_exp [4] = '{20, 40, 60, 0};

  initial begin
    rst_n = 1'b0; pwm_in = 4'b1111;
    btn_mode = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0; tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst_n = 1'b1;

    // mode press then five speed presses with only stream 1 active
    cyc("to_manual", 1, 0, 0, 0, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      cyc("speed", 0, 1, 0, 0, 4'b0010);
      chk("speed_level", 32'(o_level), 32'(sp_exp[i]));
      if (i == 1) chk("pwm_after_lvl1", 32'(o_pwm), 32'd1);
    end
    for (int i = 0; i < 3; i++) cyc("speed_back", 0, 1, 0, 0, 4'b0010);

    // sweep from level 0
    cyc("to_sweep", 1, 0, 0, 0, 4'b1010);
    for (int i = 0; i < 14; i++) begin
      cyc("sweep", 0, 0, 0, 1, 4'b1010);
      if (i % 2 == 1) chk("sweep_level", 32'(o_level), 32'(lv_exp[i / 2]));
    end

    // timer presses in manual, then countdown to auto-off
    cyc("sweep_off", 1, 0, 0, 0, 4'b1111);
    cyc("to_manual2", 1, 0, 0, 0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      cyc("timer", 0, 0, 1, 0, 4'b1111);
      if (TEN) chk("timer_sec", 32'(o_sec_left), 32'(tm_exp[i]));
    end
    cyc("timer1", 0, 0, 1, 0, 4'b1111);
    for (int i = 0; i < 20; i++) cyc("count", 0, 0, 0, 1, 4'b1111);
    if (TEN) chk("expire_mode", 32'(o_mode), 32'd0);
    cyc("after_expire", 0, 0, 0, 0, 4'b1111);
    if (TEN) chk("expire_pwm", 32'(o_pwm), 32'd0);

    // expiry beats mode press; tick plus press at 40
    do_reset();
    cyc("to_manual3", 1, 0, 0, 0, 4'b0101);
    cyc("timer20", 0, 0, 1, 0, 4'b0101);
    for (int i = 0; i < 19; i++) cyc("count19", 0, 0, 0, 1, 4'b0101);
    cyc("tick_mode", 1, 0, 0, 1, 4'b0101);
    if (TEN) begin
      chk("tick_mode_mode", 32'(o_mode), 32'd0);
      chk("tick_mode_sec", 32'(o_sec_left), 32'd0);
    end
    do_reset();
    cyc("to_manual4", 1, 0, 0, 0, 4'b0101);
    cyc("t1", 0, 0, 1, 0, 4'b0101);
    cyc("t2", 0, 0, 1, 0, 4'b0101);
    cyc("tick_timer", 0, 0, 1, 1, 4'b0101);
    if (TEN) chk("tick_timer_sec", 32'(o_sec_left), 32'd59);

    // timer presses and long run of ticks in manual
    do_reset();
    cyc("to_manual5", 1, 0, 0, 0, 4'b0011);
    for (int i = 0; i < 3; i++) cyc("t3", 0, 0, 1, 0, 4'b0011);
    for (int i = 0; i < 100; i++) cyc("t100", 0, 0, 0, 1, 4'b0011);
    if (!TEN) begin
      chk("notimer_mode", 32'(o_mode), 32'd1);
      chk("notimer_sec", 32'(o_sec_left), 32'd0);
    end

    // asynchronous reset in mid-sweep with a press held across it
    do_reset();
    cyc("to_manual6", 1, 0, 0, 0, 4'b1111);
    cyc("t_a", 0, 0, 1, 0, 4'b1111);
    cyc("to_sweep6", 1, 0, 0, 0, 4'b1111);
    for (int i = 0; i < 5; i++) cyc("sweep6", 0, 0, 0, 1, 4'b1111);
    rst_n = 1'b0; btn_mode = 1'b1;
    #2;
    chk("async_mode",  32'(o_mode),     32'd0);
    chk("async_level", 32'(o_level),    32'd0);
    chk("async_sec",   32'(o_sec_left), 32'd0);
    chk("async_pwm",   32'(o_pwm),      32'd0);
    @(posedge clk); #1;
    btn_mode = 1'b0;
    model_reset();
    rst_n = 1'b1;
    cyc("post_reset", 0, 0, 0, 0, 4'b1111);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc("rand",
          ($urandom_range(15) == 0),
          ($urandom_range(3) == 0),
          ($urandom_range(9) == 0),
          ($urandom_range(2) == 0),
          N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
